mo_mul_pipe: RTL and testbench

MO_MUL_PIPE -- requirements
Module: mo_mul_pipe

---
 rtl/mo_mul_pipe.sv | 108 ++++++++++
 tb/tb_mo_mul_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mo_mul_pipe.sv
// Multi-lane signed Montgomery multiplier pipeline with a single valid/ready handshake.
// Each beat carries its own canon bit selecting lazy (-Q,Q) or canonical [0,Q) output.
module mo_mul_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 3329,
  parameter int QINV       = 62209,
  parameter int STAGE_CNT  = 4,
  parameter int LANES      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]      a,
  input  logic [LANES*DATA_WIDTH-1:0]      b,
  input  logic                             canon,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*(DATA_WIDTH+1)-1:0]  result
);

  localparam int W  = DATA_WIDTH;
  localparam int RS = STAGE_CNT - 2;
  localparam int PW = 2 * W + 2;
  localparam logic [W-1:0]         QINV_W = W'(QINV);
  localparam logic signed [PW-1:0] Q_PW   = PW'(Q);
  localparam logic [W+1:0]         Q_U    = (W + 2)'(Q);

  // Handshake: a beat moves on a rising edge when valid && ready are both high.
  // The whole pipeline advances as one when the output slot is empty or being drained.
  logic                 adv;
  logic [STAGE_CNT-1:0] vld_q, vld_d;
  logic [1:0]           cnl_q, cnl_d;
  logic [2*W-1:0]       s1_t_q [LANES];
  logic [2*W-1:0]       s1_t_d [LANES];
  logic [2*W-1:0]       s2_t_q [LANES];
  logic [2*W-1:0]       s2_t_d [LANES];
  logic [W-1:0]         s2_m_q [LANES];
  logic [W-1:0]         s2_m_d [LANES];
  logic [W:0]           res_q  [RS][LANES];
  logic [W:0]           res_d  [RS][LANES];

  // u = (t - m*Q) >>> W; the low W bits of the difference are zero by construction.
  function automatic logic [W:0] mont_reduce(input logic [2*W-1:0] t,
                                             input logic [W-1:0]   m,
                                             input logic           cn);
    logic signed [PW-1:0] diff;
    logic [W+1:0]         u;
    diff = $signed({2'b00, t}) - $signed({{(W + 2){m[W-1]}}, m}) * Q_PW;
    u    = (W + 2)'(diff >>> W);
    if (cn && u[W+1]) u = u + Q_U;
    return u[W:0];
  endfunction

  always_comb begin
    adv       = !vld_q[STAGE_CNT-1] || out_ready;
    in_ready  = adv;
    out_valid = vld_q[STAGE_CNT-1];
    for (int k = 0; k < LANES; k++) begin
      result[k*(W+1) +: (W+1)] = res_q[RS-1][k];
    end
  end

  always_comb begin
    vld_d  = vld_q;
    cnl_d  = cnl_q;
    s1_t_d = s1_t_q;
    s2_t_d = s2_t_q;
    s2_m_d = s2_m_q;
    res_d  = res_q;
    if (adv) begin
      vld_d = {vld_q[STAGE_CNT-2:0], in_valid};
      cnl_d = {cnl_q[0], canon};
      for (int k = 0; k < LANES; k++) begin
        s1_t_d[k]   = (2 * W)'(a[k*W +: W]) * (2 * W)'(b[k*W +: W]);
        s2_t_d[k]   = s1_t_q[k];
        s2_m_d[k]   = s1_t_q[k][W-1:0] * QINV_W;
        res_d[0][k] = mont_reduce(s2_t_q[k], s2_m_q[k], cnl_q[1]);
        for (int i = 1; i < RS; i++) begin
          res_d[i][k] = res_q[i-1][k];
        end
      end
    end
  end

  // Result stages are cleared so the output bus reads zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < RS; i++) begin
        for (int k = 0; k < LANES; k++) begin
          res_q[i][k] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    cnl_q  <= cnl_d;
    s1_t_q <= s1_t_d;
    s2_t_q <= s2_t_d;
    s2_m_q <= s2_m_d;
  end

endmodule

// File: tb/tb_mo_mul_pipe.sv
// Directed bench for mo_mul_pipe: default Kyber-sized instance plus a wide 4-lane instance.
module tb_mo_mul_pipe;
  localparam int W = 16, L = 2, S = 4, Q = 3329, QINV = 62209, RW = W + 1;
  localparam int W2 = 24, L2 = 4, S2 = 5, Q2 = 8380417, QINV2 = 58728449, RW2 = W2 + 1;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, canon = 1'b0, out_valid, out_ready = 1'b0;
  logic [L*W-1:0]  a = '0, b = '0;
  logic [L*RW-1:0] result;
  logic s_in_valid = 1'b0, s_in_ready, s_canon = 1'b0, s_out_valid, s_out_ready = 1'b0;
  logic [L2*W2-1:0]  s_a = '0, s_b = '0;
  logic [L2*RW2-1:0] s_result;

  int n_cmp = 0, n_bad = 0;
  logic [L*RW-1:0] exp_q[$];
  logic [L*W-1:0]  ea_q[$], eb_q[$];
  bit              cn_q[$];
  longint lazy_min = 0, lazy_max = 0, canon_min = 0, canon_max = 0;

  always #5 clk = ~clk;

  mo_mul_pipe #(.DATA_WIDTH(W), .Q(Q), .QINV(QINV), .STAGE_CNT(S), .LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .canon(canon), .out_valid(out_valid), .out_ready(out_ready), .result(result));

  mo_mul_pipe #(.DATA_WIDTH(W2), .Q(Q2), .QINV(QINV2), .STAGE_CNT(S2), .LANES(L2)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .canon(s_canon), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference Montgomery product straight from the defining formula.
  function automatic longint mont(longint av, longint bv, bit cn, int w, longint q, longint qinv);
    longint r, t, mlo, m, u;
    r   = longint'(1) << w;
    t   = av * bv;
    mlo = ((t % r) * qinv) % r;
    m   = (mlo >= r / 2) ? mlo - r : mlo;
    u   = (t - m * q) / r;
    if (cn && u < 0) u = u + q;
    return u;
  endfunction

  function automatic logic [L*RW-1:0] exp_beat(input logic [L*W-1:0] av, input logic [L*W-1:0] bv, input bit cn);
    logic [L*RW-1:0] r;
    for (int k = 0; k < L; k++)
      r[k*RW +: RW] = RW'(mont(longint'(av[k*W +: W]), longint'(bv[k*W +: W]), cn, W, Q, QINV));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [L*W-1:0] av, input logic [L*W-1:0] bv, input bit cn,
                          output int lat, output logic [L*RW-1:0] res);
    int guard;
    guard = 0;
    a = av; b = bv; canon = cn; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    res = result;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if (s_out_valid !== 1'b0 || s_result !== '0) begin n_bad++; $display("FAIL reset_wide: got v=%b r=%h want 0", s_out_valid, s_result); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_golden();
    int lat;
    logic [L*RW-1:0] res;
    send_one({16'd2285, 16'd2285}, {16'd1234, 16'd1234}, 1'b1, lat, res);
    n_cmp++; if (lat !== S) begin n_bad++; $display("FAIL golden_latency: got %0d want %0d", lat, S); end
    n_cmp++; if (res !== {17'd1234, 17'd1234}) begin n_bad++; $display("FAIL golden_canon: got %h want %h", res, {17'd1234, 17'd1234}); end
    send_one({16'd2285, 16'd2285}, {16'd1234, 16'd1234}, 1'b0, lat, res);
    n_cmp++; if (res !== {17'd1234, 17'd1234}) begin n_bad++; $display("FAIL golden_lazy: got %h want %h", res, {17'd1234, 17'd1234}); end
  endtask

  task automatic test_edge();
    logic [L*W-1:0]  va[6], vb[6];
    bit              vc[6];
    logic [L*RW-1:0] ve[6];
    logic [L*RW-1:0] res;
    int lat;
    va[0] = {16'd1234, 16'd0};    vb[0] = {16'd0, 16'd1234};    vc[0] = 1; ve[0] = {17'd0, 17'd0};
    va[1] = {16'd3328, 16'd3328}; vb[1] = {16'd3328, 16'd3328}; vc[1] = 1; ve[1] = {17'd169, 17'd169};
    va[2] = {16'd3328, 16'd1};    vb[2] = {16'd1, 16'd3328};    vc[2] = 0; ve[2] = {17'h1FF57, 17'h1FF57};
    va[3] = {16'd3328, 16'd1};    vb[3] = {16'd1, 16'd3328};    vc[3] = 1; ve[3] = {17'd3160, 17'd3160};
    va[4] = {16'd0, 16'd2285};    vb[4] = {16'd3328, 16'd1234}; vc[4] = 1; ve[4] = {17'd0, 17'd1234};
    va[5] = {16'd2285, 16'd3328}; vb[5] = {16'd1234, 16'd3328}; vc[5] = 0; ve[5] = {17'd1234, 17'd169};
    for (int i = 0; i < 6; i++) begin
      send_one(va[i], vb[i], vc[i], lat, res);
      n_cmp++;
      if (res !== ve[i]) begin n_bad++; $display("FAIL edge_%0d: got %h want %h", i, res, ve[i]); end
    end
    send_one({16'hFFFF, 16'hFFFF}, {16'd1, 16'hFFFF}, 1'b1, lat, res);
    n_cmp++;
    if (res !== exp_beat({16'hFFFF, 16'hFFFF}, {16'd1, 16'hFFFF}, 1'b1)) begin
      n_bad++; $display("FAIL edge_over_q: got %h want %h", res, exp_beat({16'hFFFF, 16'hFFFF}, {16'd1, 16'hFFFF}, 1'b1));
    end
  endtask

  task automatic run_stream(input int n, input bit bp);
    int sent, got, cyc;
    bit prev_stall, cn;
    logic [L*RW-1:0] prev_res, want, got_v;
    logic [L*W-1:0]  na, nb, oa, ob;
    longint v, lhs, rhs;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; prev_res = '0;
    for (int k = 0; k < L; k++) begin na[k*W +: W] = W'($urandom_range(0, Q - 1)); nb[k*W +: W] = W'($urandom_range(0, Q - 1)); end
    while ((sent < n || got < n) && cyc < 400) begin
      in_valid = (sent < n);
      a = na; b = nb; canon = sent[0];
      out_ready = bp ? ((cyc < 10) ? 1'b0 : cyc[0]) : 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin n_bad++; $display("FAIL stream_in_ready: cyc %0d got %b want %b", cyc, in_ready, !out_valid || out_ready); end
      if (prev_stall && out_valid) begin
        n_cmp++;
        if (result !== prev_res) begin n_bad++; $display("FAIL stream_hold: cyc %0d got %h want %h", cyc, result, prev_res); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra: got %h want nothing", result);
        end else begin
          want = exp_q.pop_front(); cn = cn_q.pop_front(); oa = ea_q.pop_front(); ob = eb_q.pop_front();
          got_v = result;
          if (got_v !== want) begin n_bad++; $display("FAIL stream_data: beat %0d got %h want %h", got, got_v, want); end
          for (int k = 0; k < L; k++) begin
            v = longint'($signed(got_v[k*RW +: RW]));
            lhs = (((v % Q) + Q) % Q) * 65536 % Q;
            rhs = (longint'(oa[k*W +: W]) * longint'(ob[k*W +: W])) % Q;
            n_cmp++;
            if (lhs != rhs || (cn && (v < 0 || v >= Q)) || (!cn && (v <= -Q || v >= Q))) begin
              n_bad++; $display("FAIL stream_range: lane %0d got %0d congr %0d want congr %0d canon %0d", k, v, lhs, rhs, cn);
            end
            if (cn) begin if (v < canon_min) canon_min = v; if (v > canon_max) canon_max = v; end
            else begin if (v < lazy_min) lazy_min = v; if (v > lazy_max) lazy_max = v; end
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res = result;
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_beat(a, b, canon)); cn_q.push_back(canon); ea_q.push_back(a); eb_q.push_back(b);
        sent++;
        for (int k = 0; k < L; k++) begin na[k*W +: W] = W'($urandom_range(0, Q - 1)); nb[k*W +: W] = W'($urandom_range(0, Q - 1)); end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (sent != n || got != n || exp_q.size() != 0) begin n_bad++; $display("FAIL stream_count: sent %0d got %0d left %0d want %0d", sent, got, exp_q.size(), n); end
    got = 0;
    repeat (S + 2) begin #1; if (out_valid) got++; tick(); end
    n_cmp++;
    if (got != 0) begin n_bad++; $display("FAIL stream_dup: got %0d extra beats want 0", got); end
  endtask

  task automatic test_back_to_back();
    run_stream(24, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream(20, 1'b1);
  endtask

  task automatic test_reset_midstream();
    int seen, lat;
    logic [L*RW-1:0] res;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = {16'd100, 16'(i + 7)}; b = {16'd200, 16'd300}; canon = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got %b want 1", out_valid); end
    #2; rst = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL midrst_result: got %h want 0", result); end
    tick();
    rst = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (10) begin #1; if (out_valid) seen++; tick(); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_ghost: got %0d beats want 0", seen); end
    send_one({16'd2285, 16'd2285}, {16'd1234, 16'd1234}, 1'b1, lat, res);
    n_cmp++; if (lat !== S) begin n_bad++; $display("FAIL midrst_latency: got %0d want %0d", lat, S); end
    n_cmp++; if (res !== {17'd1234, 17'd1234}) begin n_bad++; $display("FAIL midrst_data: got %h want %h", res, {17'd1234, 17'd1234}); end
  endtask

  task automatic test_sweep();
    logic [L2*W2-1:0] va, vb;
    int lat;
    longint v, want, lhs, rhs, rm;
    rm = (longint'(1) << W2) % Q2;
    s_out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t < 2) begin
        va = {24'(Q2 - 1), 24'd0, 24'd1, 24'd12345};
        vb = {24'(Q2 - 1), 24'd777, 24'd1, 24'd4000000};
      end else begin
        for (int k = 0; k < L2; k++) begin va[k*W2 +: W2] = W2'($urandom_range(0, Q2 - 1)); vb[k*W2 +: W2] = W2'($urandom_range(0, Q2 - 1)); end
      end
      s_a = va; s_b = vb; s_canon = (t % 2 == 0); s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 50) begin tick(); lat++; end
      n_cmp++; if (lat != S2) begin n_bad++; $display("FAIL sweep_latency: got %0d want %0d", lat, S2); end
      for (int k = 0; k < L2; k++) begin
        v = longint'($signed(s_result[k*RW2 +: RW2]));
        want = mont(longint'(va[k*W2 +: W2]), longint'(vb[k*W2 +: W2]), s_canon, W2, Q2, QINV2);
        lhs = (((v % Q2) + Q2) % Q2) * rm % Q2;
        rhs = (longint'(va[k*W2 +: W2]) * longint'(vb[k*W2 +: W2])) % Q2;
        n_cmp++;
        if (v != want || lhs != rhs || (s_canon && (v < 0 || v >= Q2)) || (!s_canon && (v <= -Q2 || v >= Q2))) begin
          n_bad++; $display("FAIL sweep_lane%0d: beat %0d got %0d want %0d", k, t, v, want);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_edge();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("observed lazy min %0d max %0d, canonical min %0d max %0d", lazy_min, lazy_max, canon_min, canon_max);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
